// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between fetch and data ports; one transaction in flight.
// Data wins arbitration; a run counter forces a fetch grant after MAX_DATA_RUN data grants.
module mem_port_arbiter #(
  parameter int MAX_DATA_RUN = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_ready,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rvalid,
  output logic        i_stall,
  output logic        d_stall,
  output logic        busy,
  output logic        bus_err
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} state_t;

  localparam logic [3:0] RUN_MAX  = 4'(MAX_DATA_RUN);
  localparam logic [7:0] TMO_LAST = 8'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam bit         TMO_EN   = (TIMEOUT != 0);

  state_t      state_q, state_d;
  logic        owner_q, owner_d;  // 1 = data port
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  run_q, run_d;
  logic [7:0]  tmo_q, tmo_d;
  logic [31:0] i_rdata_q, i_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        i_ready_q, i_ready_d;
  logic        d_ready_q, d_ready_d;
  logic        bus_err_q, bus_err_d;

  logic i_elig, d_elig, grant_i, grant_d;

  // A port's request is not re-arbitrated in the cycle its previous one completes.
  assign i_elig = i_req & ~i_ready_q;
  assign d_elig = d_req & ~d_ready_q;

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    run_d     = run_q;
    tmo_d     = tmo_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    i_ready_d = 1'b0;
    d_ready_d = 1'b0;
    bus_err_d = 1'b0;
    grant_i   = 1'b0;
    grant_d   = 1'b0;

    case (state_q)
      IDLE: begin
        grant_i = i_elig & (~d_elig | (run_q == RUN_MAX));
        grant_d = d_elig & ~grant_i;
        if (grant_i) begin
          owner_d = 1'b0;
          we_d    = 1'b0;
          addr_d  = i_addr & 32'hFFFF_FFFC;
          wdata_d = 32'h0;
          run_d   = 4'd0;
          state_d = ISSUE;
        end else if (grant_d) begin
          owner_d = 1'b1;
          we_d    = d_we;
          addr_d  = d_addr & 32'hFFFF_FFFC;
          wdata_d = d_wdata;
          if (!i_req) begin
            run_d = 4'd0;
          end else if (run_q != RUN_MAX) begin
            run_d = run_q + 4'd1;
          end
          state_d = ISSUE;
        end
      end

      ISSUE: begin
        tmo_d   = 8'd0;
        state_d = WAIT;
      end

      WAIT: begin
        if (mem_rvalid) begin
          state_d = IDLE;
          if (owner_q) begin
            d_ready_d = 1'b1;
            if (!we_q) d_rdata_d = mem_rdata;
          end else begin
            i_ready_d = 1'b1;
            i_rdata_d = mem_rdata;
          end
        end else if (TMO_EN && (tmo_q == TMO_LAST)) begin
          state_d   = IDLE;
          bus_err_d = 1'b1;
          if (owner_q) begin
            d_ready_d = 1'b1;
            d_rdata_d = 32'h0;
          end else begin
            i_ready_d = 1'b1;
            i_rdata_d = 32'h0;
          end
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= 32'h0;
      wdata_q   <= 32'h0;
      run_q     <= 4'd0;
      tmo_q     <= 8'd0;
      i_rdata_q <= 32'h0;
      d_rdata_q <= 32'h0;
      i_ready_q <= 1'b0;
      d_ready_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      run_q     <= run_d;
      tmo_q     <= tmo_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      i_ready_q <= i_ready_d;
      d_ready_q <= d_ready_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign mem_en    = (state_q == ISSUE);
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign i_ready   = i_ready_q;
  assign d_ready   = d_ready_q;
  assign bus_err   = bus_err_q;
  assign busy      = (state_q != IDLE);
  assign i_stall   = i_req & ~i_ready_q;
  assign d_stall   = d_req & ~d_ready_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a transaction-level reference model.
// Each transaction is tracked by its grant/issue/completion cycle numbers.
module tb_mem_port_arbiter;
  localparam int MAXRUN = 1;
  localparam int TMO    = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0, mem_rvalid = 1'b0;
  logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0, mem_rdata = '0;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
  logic        i_ready, d_ready, mem_en, mem_we, i_stall, d_stall, busy, bus_err;

  mem_port_arbiter #(.MAX_DATA_RUN(MAXRUN), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .i_stall(i_stall), .d_stall(d_stall), .busy(busy), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  req_t        iq[$], dq[$];
  int          lat_q[$];          // -1: memory never answers
  logic [31:0] mem_m [logic [31:0]];

  int vec = 0, bad = 0, cyc = 0;
  bit rnd = 0, rst_now = 1;
  int ist = 0, dst = 0;           // requester: 0 free, 1 waiting for grant, 2 granted

  // Transaction in flight and expected architectural outputs
  bit          t_vld = 0, t_own = 0, t_we = 0, t_err = 0;
  int          t_iss = 0, t_done = 0;
  logic [31:0] t_rd = '0;
  int          run = 0;
  logic [31:0] e_maddr = '0, e_mwdata = '0, e_ird = '0, e_drd = '0;
  bit          e_mwe = 0;
  int          rv_cyc = -1;
  logic [31:0] rv_dat = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic req_t rand_req(input bit is_d);
    req_t r;
    r.we    = is_d ? 1'($urandom_range(1)) : 1'b0;
    r.addr  = 32'($urandom_range(255));
    r.wdata = $urandom;
    return r;
  endfunction

  task automatic model_reset();
    t_vld = 0; run = 0; ist = 0; dst = 0;
    e_maddr = '0; e_mwdata = '0; e_mwe = 0; e_ird = '0; e_drd = '0;
  endtask

  task automatic drive();
    req_t r;
    int   c;
    c = cyc;
    rst = rst_now;
    mem_rvalid = (c == rv_cyc);
    mem_rdata  = (c == rv_cyc) ? rv_dat : $urandom;
    if (rnd && !mem_rvalid && !(t_vld && c > t_iss && c < t_done) && $urandom_range(5) == 0)
      mem_rvalid = 1'b1;
    if (rst_now) begin
      i_req = 1'b0;
      d_req = 1'b0;
    end else begin
      if (ist == 0) begin
        if (iq.size() > 0) begin r = iq.pop_front(); ist = 1; end
        else if (rnd && $urandom_range(2) == 0) begin r = rand_req(0); ist = 1; end
        i_req = (ist == 1);
        if (ist == 1) i_addr = r.addr;
      end else if (ist == 2 && rnd) begin
        if ($urandom_range(7) == 0) i_addr = $urandom;
        if ($urandom_range(15) == 0) i_req = 1'b0;
      end
      if (dst == 0) begin
        if (dq.size() > 0) begin r = dq.pop_front(); dst = 1; end
        else if (rnd && $urandom_range(2) == 0) begin r = rand_req(1); dst = 1; end
        d_req = (dst == 1);
        if (dst == 1) begin d_we = r.we; d_addr = r.addr; d_wdata = r.wdata; end
      end else if (dst == 2 && rnd) begin
        if ($urandom_range(7) == 0) begin d_addr = $urandom; d_wdata = $urandom; d_we = ~d_we; end
        if ($urandom_range(15) == 0) d_req = 1'b0;
      end
    end
  endtask

  task automatic arbitrate(input int c, input bit ri, input bit rd);
    bit ie, de, gi, gd;
    int L, k;
    ie = i_req && !ri;
    de = d_req && !rd;
    gi = ie && (!de || run == MAXRUN);
    gd = de && !gi;
    if (gi || gd) begin
      t_vld    = 1;
      t_own    = gd;
      t_we     = gd ? d_we : 1'b0;
      e_maddr  = (gd ? d_addr : i_addr) & 32'hFFFF_FFFC;
      e_mwdata = gd ? d_wdata : 32'h0;
      e_mwe    = t_we;
      if (gd) run = i_req ? ((run < MAXRUN) ? run + 1 : run) : 0;
      else    run = 0;
      if (gd) dst = 2; else ist = 2;
      if (t_we) begin
        mem_m[e_maddr] = e_mwdata;
        t_rd = $urandom;
      end else begin
        t_rd = mem_m.exists(e_maddr) ? mem_m[e_maddr] : {e_maddr[15:0], 16'hBEEF};
      end
      if (lat_q.size() > 0) L = lat_q.pop_front();
      else begin
        k = $urandom_range(9);
        L = (k <= 5) ? k + 1 : (k == 6) ? 8 : (k == 7) ? 9 : (k == 8) ? -1 : 2;
      end
      t_iss = c + 1;
      t_err = (L < 0 || L > TMO);
      t_done = t_err ? c + 2 + TMO : c + 2 + L;
      rv_cyc = (L < 0) ? -1 : c + 1 + L;
      rv_dat = t_rd;
    end
  endtask

  task automatic check_cycle();
    int c;
    bit ri, rd, er;
    c = cyc; ri = 0; rd = 0; er = 0;
    if (rst) model_reset();
    else if (t_vld && c == t_done) begin
      ri = !t_own; rd = t_own; er = t_err;
      if (t_own) begin
        if (t_err) e_drd = 32'h0;
        else if (!t_we) e_drd = t_rd;
      end else begin
        e_ird = t_err ? 32'h0 : t_rd;
      end
    end
    chk("mem_en",    32'(mem_en),    32'(t_vld && c == t_iss));
    chk("mem_we",    32'(mem_we),    32'(e_mwe));
    chk("mem_addr",  mem_addr,       e_maddr);
    chk("mem_wdata", mem_wdata,      e_mwdata);
    chk("i_ready",   32'(i_ready),   32'(ri));
    chk("d_ready",   32'(d_ready),   32'(rd));
    chk("i_rdata",   i_rdata,        e_ird);
    chk("d_rdata",   d_rdata,        e_drd);
    chk("bus_err",   32'(bus_err),   32'(er));
    chk("busy",      32'(busy),      32'(t_vld && c >= t_iss && c < t_done));
    chk("i_stall",   32'(i_stall),   32'(i_req && !ri));
    chk("d_stall",   32'(d_stall),   32'(d_req && !rd));
    chk("one_ready", 32'(i_ready && d_ready), 32'd0);
    if (!rst) begin
      if (t_vld && c == t_done) begin
        t_vld = 0;
        if (t_own) dst = 0; else ist = 0;
      end
      if (!t_vld) arbitrate(c, ri, rd);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    drive();
    @(negedge clk);
    check_cycle();
    cyc++;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((t_vld || ist != 0 || dst != 0 || iq.size() > 0 || dq.size() > 0) && n < 300) begin
      step();
      n++;
    end
    chk("drain_bound", 32'(n < 300), 32'd1);
  endtask

  initial begin
    mem_m[32'h104] = 32'h2408_0005;
    rst_now = 1;
    repeat (2) step();
    rst_now = 0;
    step();

    // single fetch, L=1
    iq.push_back('{1'b0, 32'h104, 32'h0}); lat_q.push_back(1);
    drain();
    chk("fetch_data", i_rdata, 32'h2408_0005);

    // store then load the same word
    dq.push_back('{1'b1, 32'h42, 32'hCAFE_F00D}); lat_q.push_back(2);
    dq.push_back('{1'b0, 32'h40, 32'h0});         lat_q.push_back(3);
    drain();
    chk("store_load", d_rdata, 32'hCAFE_F00D);

    // load that never gets a response
    dq.push_back('{1'b0, 32'h80, 32'h0}); lat_q.push_back(-1);
    dq.push_back('{1'b0, 32'h40, 32'h0}); lat_q.push_back(1);
    drain();
    chk("after_timeout", d_rdata, 32'hCAFE_F00D);

    // contention, then a long-latency fetch
    for (int k = 0; k < 4; k++) dq.push_back('{1'b0, 32'(k * 4), 32'h0});
    for (int k = 0; k < 3; k++) iq.push_back('{1'b0, 32'(k * 4 + 8'h10), 32'h0});
    drain();
    iq.push_back('{1'b0, 32'h104, 32'h0}); lat_q.push_back(5);
    drain();

    rnd = 1;
    repeat (3000) step();
    rnd = 0;
    drain();

    // reset while waiting, then a stale response arrives
    iq.push_back('{1'b0, 32'h200, 32'h0}); lat_q.push_back(-1);
    repeat (5) step();
    chk("busy_before_reset", 32'(busy), 32'd1);
    rst_now = 1;
    repeat (2) step();
    rst_now = 0;
    step();
    rv_cyc = cyc + 1;
    rv_dat = 32'h1234_5678;
    repeat (6) step();
    chk("busy_after_reset", 32'(busy), 32'd0);
    chk("i_rdata_after_reset", i_rdata, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule
